// File: rtl/nios2_cpu_mult_iter.sv
// Iterative multiplier: one LANE_W x LANE_W unsigned partial product per cycle,
// followed by a single sign-correction step for the high-half (MULX*) modes.
module nios2_cpu_mult_iter #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] M_mul_src1,
  input  logic [DATA_W-1:0] M_mul_src2,
  input  logic [1:0]        M_mul_mode,
  input  logic              M_mul_start,
  input  logic              M_mul_abort,
  input  logic              M_mul_ack,
  output logic              M_mul_ready,
  output logic              M_mul_busy,
  output logic              M_mul_result_valid,
  output logic [DATA_W-1:0] M_mul_cell_result
);

  localparam int K     = DATA_W / LANE_W;
  localparam int NPP   = K * K;
  localparam int CNT_W = (NPP > 1) ? $clog2(NPP) : 1;
  localparam int ACC_W = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CORR, S_DONE} state_t;

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULXSS = 2'b01;
  localparam logic [1:0] MODE_MULXSU = 2'b10;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [1:0]          r_mode;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_result;

  logic                w_accept;
  logic                w_last;
  logic [CNT_W-1:0]    w_i;
  logic [CNT_W-1:0]    w_j;
  logic [LANE_W-1:0]   w_a_slice;
  logic [LANE_W-1:0]   w_b_slice;
  logic [2*LANE_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_pp;
  logic                w_a_signed;
  logic                w_b_signed;
  logic [ACC_W-1:0]    w_corr;
  logic [DATA_W-1:0]   w_res;

  // Abort in IDLE wins over start, so nothing is accepted on that edge.
  assign w_accept = (r_state == S_IDLE) && M_mul_start && !M_mul_abort;
  assign w_last   = (r_cnt == CNT_W'(NPP - 1));

  // Counter value is i*K + j: i selects the A slice, j the B slice.
  assign w_i       = r_cnt / CNT_W'(K);
  assign w_j       = r_cnt % CNT_W'(K);
  assign w_a_slice = LANE_W'(r_a >> (int'(w_i) * LANE_W));
  assign w_b_slice = LANE_W'(r_b >> (int'(w_j) * LANE_W));
  assign w_prod    = {{LANE_W{1'b0}}, w_a_slice} * {{LANE_W{1'b0}}, w_b_slice};
  assign w_pp      = ACC_W'(w_prod) << ((int'(w_i) + int'(w_j)) * LANE_W);

  // Unsigned product minus the weight the sign bit should have carried.
  assign w_a_signed = (r_mode == MODE_MULXSS) || (r_mode == MODE_MULXSU);
  assign w_b_signed = (r_mode == MODE_MULXSS);
  assign w_corr = r_acc
                - ((w_a_signed && r_a[DATA_W-1]) ? {r_b, {DATA_W{1'b0}}} : '0)
                - ((w_b_signed && r_b[DATA_W-1]) ? {r_a, {DATA_W{1'b0}}} : '0);
  assign w_res  = (r_mode == MODE_MUL) ? w_corr[DATA_W-1:0] : w_corr[ACC_W-1:DATA_W];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_MUL;
      S_MUL:  if (M_mul_abort) w_next = S_IDLE;
              else if (w_last) w_next = S_CORR;
      S_CORR: if (M_mul_abort) w_next = S_IDLE;
              else w_next = S_DONE;
      S_DONE: if (M_mul_abort || M_mul_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the cleared result
  // is architecturally visible on M_mul_cell_result after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a    <= M_mul_src1;
      r_b    <= M_mul_src2;
      r_mode <= M_mul_mode;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_MUL && !M_mul_abort) begin
      r_acc <= r_acc + w_pp;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end else if (r_state == S_CORR && !M_mul_abort) begin
      r_acc    <= w_corr;
      r_result <= w_res;
    end
  end

  assign M_mul_ready        = (r_state == S_IDLE);
  assign M_mul_busy         = (r_state == S_MUL) || (r_state == S_CORR);
  assign M_mul_result_valid = (r_state == S_DONE);
  assign M_mul_cell_result  = r_result;

endmodule

// File: tb/tb_nios2_cpu_mult_iter.sv
// Runs a 32/16 and a 64/16 instance side by side on shared stimulus and
// checks both against an arithmetic reference model.
module tb_nios2_cpu_mult_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;

  logic        r32_ready, r32_busy, r32_valid;
  logic [31:0] r32_result;
  logic        r64_ready, r64_busy, r64_valid;
  logic [63:0] r64_result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_e32 = '0;
  logic [63:0] last_e64 = '0;

  always #5 clk = ~clk;

  nios2_cpu_mult_iter #(.DATA_W(32), .LANE_W(16)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .M_mul_src1(a[31:0]), .M_mul_src2(b[31:0]), .M_mul_mode(mode),
    .M_mul_start(start), .M_mul_abort(abort), .M_mul_ack(ack),
    .M_mul_ready(r32_ready), .M_mul_busy(r32_busy),
    .M_mul_result_valid(r32_valid), .M_mul_cell_result(r32_result)
  );

  nios2_cpu_mult_iter #(.DATA_W(64), .LANE_W(16)) u_dut64 (
    .clk(clk), .reset_n(reset_n),
    .M_mul_src1(a), .M_mul_src2(b), .M_mul_mode(mode),
    .M_mul_start(start), .M_mul_abort(abort), .M_mul_ack(ack),
    .M_mul_ready(r64_ready), .M_mul_busy(r64_busy),
    .M_mul_result_valid(r64_valid), .M_mul_cell_result(r64_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Treat each operand as a w-bit signed or unsigned integer, multiply exactly,
  // then take the requested half.
  function automatic logic [63:0] ref_mul(input logic [63:0] a_in, input logic [63:0] b_in,
                                          input logic [1:0] m, input int w);
    logic signed [131:0] av, bv, p;
    logic [131:0] mask;
    bit as, bs;
    mask = (132'(1) << w) - 132'(1);
    as = (m == 2'b01) || (m == 2'b10);
    bs = (m == 2'b01);
    av = {68'b0, a_in} & mask;
    bv = {68'b0, b_in} & mask;
    if (as && a_in[w-1]) av = av - $signed(132'(1) << w);
    if (bs && b_in[w-1]) bv = bv - $signed(132'(1) << w);
    p = av * bv;
    if (m == 2'b00) return 64'(p & mask);
    return 64'((p >> w) & mask);
  endfunction

  task automatic check_idle_outputs(input string tag, input logic [31:0] e32, input logic [63:0] e64);
    check({tag, "_ready32"}, 64'(r32_ready), 64'd1);
    check({tag, "_busy32"},  64'(r32_busy),  64'd0);
    check({tag, "_valid32"}, 64'(r32_valid), 64'd0);
    check({tag, "_res32"},   64'(r32_result), 64'(e32));
    check({tag, "_ready64"}, 64'(r64_ready), 64'd1);
    check({tag, "_busy64"},  64'(r64_busy),  64'd0);
    check({tag, "_valid64"}, 64'(r64_valid), 64'd0);
    check({tag, "_res64"},   r64_result, e64);
  endtask

  // Counts result_valid samples over n cycles; must stay zero.
  task automatic expect_no_valid(input string tag, input int n);
    int seen = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (r32_valid || r64_valid) seen++;
    end
    check({tag, "_no_valid"}, 64'(seen), 64'd0);
  endtask

  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_, input logic [1:0] tm,
                       input bit glitch, input bit ack_start, input bit use_exp,
                       input logic [31:0] exp32);
    int lat32 = -1, lat64 = -1, busy32_n = 0, busy64_n = 0;
    logic [63:0] e64;
    logic [31:0] e32;
    e64 = ref_mul(ta, tb_, tm, 64);
    e32 = use_exp ? exp32 : 32'(ref_mul(ta, tb_, tm, 32));
    @(negedge clk);
    a = ta; b = tb_; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && lat64 < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (glitch && c == 2) begin a = ~ta; b = ta; mode = ~tm; start = 1'b1; end
      if (glitch && c == 3) start = 1'b0;
      if (r32_busy) busy32_n++;
      if (r64_busy) busy64_n++;
      if (r32_valid && lat32 < 0) lat32 = c;
      if (r64_valid && lat64 < 0) lat64 = c;
    end
    check("lat32", 64'(lat32), 64'd5);
    check("lat64", 64'(lat64), 64'd17);
    check("busy_cycles32", 64'(busy32_n), 64'd5);
    check("busy_cycles64", 64'(busy64_n), 64'd17);
    check("valid32_held", 64'(r32_valid), 64'd1);
    check("result32", 64'(r32_result), 64'(e32));
    check("result64", r64_result, e64);
    @(negedge clk);
    ack = 1'b1;
    if (ack_start) begin a = 64'h1234_5678_9abc_def0; b = 64'd3; start = 1'b1; end
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    check("ack_ready32", 64'(r32_ready), 64'd1);
    check("ack_ready64", 64'(r64_ready), 64'd1);
    check("ack_busy32", 64'(r32_busy), 64'd0);
    check("ack_result32_kept", 64'(r32_result), 64'(e32));
    last_e32 = e32;
    last_e64 = e64;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  mode;
    logic [31:0] exp32;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{64'd7,          64'd6,          2'b00, 32'h0000_002A};
    vecs[1] = '{64'hFFFF_FFFF,  64'hFFFF_FFFF,  2'b01, 32'h0000_0000};
    vecs[2] = '{64'hFFFF_FFFF,  64'hFFFF_FFFF,  2'b11, 32'hFFFF_FFFE};
    vecs[3] = '{64'hFFFF_FFFF,  64'hFFFF_FFFF,  2'b10, 32'hFFFF_FFFF};
    vecs[4] = '{64'hFFFF_FFFF,  64'hFFFF_FFFF,  2'b00, 32'h0000_0001};
    vecs[5] = '{64'h8000_0000,  64'h8000_0000,  2'b01, 32'h4000_0000};
    vecs[6] = '{64'h8000_0000,  64'd2,          2'b00, 32'h0000_0000};

    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset", 32'd0, 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // First accept lands on the first edge after release; vec 0 also carries
    // an ignored mid-operation start, vec 1 a start coincident with ack.
    for (int i = 0; i < 7; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].mode, i == 0, i == 1, 1'b1, vecs[i].exp32);
    expect_no_valid("after_ack_start", 20);

    for (int i = 0; i < 40; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 1) ra[63] = 1'b1;
      if (i % 8 == 2) rb[31] = 1'b1;
      do_op(ra, rb, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, 32'd0);
    end

    // Abort on the third MUL edge: straight back to IDLE, old result kept.
    @(negedge clk);
    a = 64'hDEAD_BEEF_0BAD_F00D; b = 64'h0123_4567_89AB_CDEF; mode = 2'b11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_idle_outputs("abort_mul", last_e32, last_e64);
    expect_no_valid("after_abort", 20);

    // Abort with start in IDLE: not accepted.
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    check_idle_outputs("abort_idle", last_e32, last_e64);

    // Reset mid-MUL: outputs return to reset values without waiting for a clock.
    @(negedge clk);
    a = 64'd99; b = 64'd77; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 reset_n = 1'b0;
    #1 check_idle_outputs("reset_mid", 32'd0, 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    expect_no_valid("after_reset", 20);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
